priority_encoder_seq: RTL and testbench
=======================================

PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of input request bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0, SHALL set scan order: 0 = lowest set bit first, 1 = highest set bit first.
REQ-003 Derived constant IDX_W = clog2(WIDTH) SHALL set the index width; WIDTH=8 gives 3.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds a vector to encode.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a vector this cycle.
REQ-008 in_data  input  WIDTH  SHALL be the request vector; any bit pattern is legal, including zero and multi-hot.
REQ-009 out_valid  output  1  SHALL indicate that out_index and out_last are valid.
REQ-010 out_ready  input  1  SHALL be the downstream acceptance of the current index beat.
REQ-011 out_index  output  IDX_W  SHALL be the bit position of the current set bit.
REQ-012 out_last  output  1  SHALL mark the final index beat of the current vector.
REQ-013 out_multi  output  1  SHALL be high for every beat of a vector with more than one set bit.
REQ-014 zero_pulse  output  1  SHALL pulse high for one cycle when an all-zero vector is accepted.

Function
REQ-015 The FSM SHALL have two states: IDLE (no pending bits) and EMIT (pending register non-zero).
REQ-016 An input handshake SHALL occur when in_valid && in_ready are high on a rising edge.
REQ-017 in_ready SHALL be high in IDLE, and in EMIT only in a cycle where out_valid && out_ready && out_last are all high.
REQ-018 On a handshake with non-zero in_data, the block SHALL capture in_data into a pending register, latch out_multi = (popcount>1), and enter EMIT.
REQ-019 On a handshake with in_data == 0, the block SHALL stay in or return to IDLE, produce no beat, and assert zero_pulse in the following cycle only.
REQ-020 Latency SHALL be one cycle: out_valid rises in the cycle after the accepting edge.
REQ-021 In EMIT, out_valid SHALL be 1, and out_index SHALL be the lowest set pending bit (MSB_FIRST=0) or the highest (MSB_FIRST=1).
REQ-022 out_last SHALL be 1 exactly when one pending bit remains.
REQ-023 On out_valid && out_ready, the block SHALL clear the emitted bit from the pending register; throughput SHALL be one beat per cycle.
REQ-024 While out_valid && !out_ready, out_index, out_last and out_multi SHALL be held stable.
REQ-025 On the last-beat handshake with no simultaneous input handshake, the block SHALL return to IDLE, and out_valid SHALL be 0 in the next cycle.
REQ-026 On a last-beat handshake with a simultaneous input handshake, the block SHALL load the new vector with no idle cycle; a zero vector follows REQ-019.
REQ-027 A vector with N set bits SHALL produce exactly N beats, each index exactly once, in scan order.
REQ-028 in_data SHALL be ignored while in_ready is low.

Reset
REQ-029 When rst_n is low, the block SHALL immediately, without waiting for a clock edge, force IDLE, clear the pending register, and drive out_valid, out_index, out_last, out_multi and zero_pulse to 0.
REQ-030 A reset asserted mid-emission SHALL discard the remaining beats; in_ready SHALL be 1 on the first edge after rst_n rises.

Verification (WIDTH=8)
REQ-031 MSB_FIRST=0, in_data=8'b0000_0100, out_ready=1 -> one beat next cycle: index 2, last=1, multi=0; IDLE after.
REQ-032 in_data=8'b1001_0010, out_ready=1 -> indices 1,4,7 on consecutive cycles, last on 7, multi=1; with MSB_FIRST=1 -> indices 7,4,1.
REQ-033 in_data=8'b0000_1001, out_ready low for 3 cycles -> index 0 held for 3 cycles; then 0,3 once out_ready rises.
REQ-034 in_data=8'h00 -> zero_pulse high exactly 1 cycle; out_valid stays 0; in_ready stays 1.
REQ-035 8'b0000_0011, then 8'b1000_0000 presented on the last-beat cycle -> beats 0,1,7 with no gap; last high on beats 1 and 7.
REQ-036 rst_n low during the second beat of 8'hFF -> all outputs 0 at once; after release, 8'h01 yields a single index-0 beat.

Source files
------------

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: accepts a request vector and emits the index of
// each set bit, one beat per cycle, in LSB-first or MSB-first scan order.
module priority_encoder_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_multi,
  output logic             zero_pulse
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pend_after;
  logic [WIDTH-1:0] pend_next;
  logic [IDX_W-1:0] index_next;
  logic             last_next;
  logic             multi_next;
  logic             zero_next;
  logic             in_hs;
  logic             out_hs;

  // Position of the first set bit in scan order; zero when the vector is empty.
  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic many(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) != '0;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      out_multi  <= 1'b0;
      zero_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      pending    <= pend_next;
      out_index  <= index_next;
      out_last   <= last_next;
      out_multi  <= multi_next;
      zero_pulse <= zero_next;
    end
  end

  // Next state follows whether any bits remain pending
  always_comb begin
    state_next = IDLE;
    if (pend_next != '0) state_next = EMIT;
  end

  // Handshakes and next values of the pending vector and beat outputs
  always_comb begin
    out_valid  = (state == EMIT);
    out_hs     = out_valid && out_ready;
    in_ready   = (state == IDLE) || (out_hs && out_last);
    in_hs      = in_valid && in_ready;
    pend_after = pending;
    if (out_hs) pend_after = pending & ~(WIDTH'(1) << out_index);
    pend_next  = pend_after;
    multi_next = out_multi;
    zero_next  = 1'b0;
    if (in_hs) begin
      pend_next  = in_data;
      multi_next = many(in_data);
      zero_next  = (in_data == '0);
    end
    if (pend_next == '0) multi_next = 1'b0;
    index_next = pick(pend_next);
    last_next  = (pend_next != '0) && !many(pend_next);
  end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Table-driven bench for priority_encoder_seq, LSB-first and MSB-first instances
// driven in parallel, plus an asynchronous reset during emission.
module tb_priority_encoder_seq;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       v;
    logic [2:0] idx;
    logic [2:0] idx_m;
    logic       last;
    logic       multi;
    logic       zero;
    logic       rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;

  logic       rdy0, v0, last0, multi0, zero0;
  logic [2:0] idx0;
  logic       rdy1, v1, last1, multi1, zero1;
  logic [2:0] idx1;

  int errors = 0;
  int checks = 0;
  int row = -1;
  vec_t tbl[$];

  always #5 clk = ~clk;

  priority_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(v0), .out_ready(out_ready),
    .out_index(idx0), .out_last(last0), .out_multi(multi0), .zero_pulse(zero0)
  );

  priority_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(v1), .out_ready(out_ready),
    .out_index(idx1), .out_last(last1), .out_multi(multi1), .zero_pulse(zero1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic v, input logic [2:0] idx, input logic [2:0] idx_m,
                     input logic last, input logic multi, input logic zero,
                     input logic rdy);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.v = v; r.idx = idx; r.idx_m = idx_m;
    r.last = last; r.multi = multi; r.zero = zero; r.rdy = rdy;
    tbl.push_back(r);
  endtask

  task automatic idle_row(input logic iv, input logic [7:0] d, input logic ordy);
    add(iv, d, ordy, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Inputs change 2 time units after the edge, outputs are sampled 2 later.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
    @(posedge clk);
    #2;
    in_valid = iv; in_data = d; out_ready = ordy;
    #2;
  endtask

  task automatic chk_both_idle(input string tag);
    chk({tag, "_valid0"}, 8'(v0), 8'h0);
    chk({tag, "_index0"}, 8'(idx0), 8'h0);
    chk({tag, "_last0"},  8'(last0), 8'h0);
    chk({tag, "_multi0"}, 8'(multi0), 8'h0);
    chk({tag, "_zero0"},  8'(zero0), 8'h0);
    chk({tag, "_valid1"}, 8'(v1), 8'h0);
    chk({tag, "_index1"}, 8'(idx1), 8'h0);
    chk({tag, "_multi1"}, 8'(multi1), 8'h0);
    chk({tag, "_zero1"},  8'(zero1), 8'h0);
  endtask

  initial begin
    // single bit 0x04
    idle_row(1'b0, 8'h00, 1'b1);
    idle_row(1'b1, 8'h04, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);
    // multi-hot 0x92
    idle_row(1'b1, 8'h92, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);
    // 0x09 with a 3-cycle downstream stall
    idle_row(1'b1, 8'h09, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);
    // all-zero vector from idle
    idle_row(1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);
    // 0x03 then 0x80 loaded on the last beat, no gap
    idle_row(1'b1, 8'h03, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h80, 1'b1, 1'b1, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);
    // input offered while not ready is ignored
    idle_row(1'b1, 8'h06, 1'b1);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);
    // zero vector accepted on a last beat
    idle_row(1'b1, 8'h01, 1'b1);
    add(1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_row(1'b0, 8'h00, 1'b1);

    // outputs while reset is held
    #12;
    chk_both_idle("in_reset");
    chk("in_reset_ready0", 8'(rdy0), 8'h1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      row = i;
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk("valid0", 8'(v0), 8'(tbl[i].v));
      chk("index0", 8'(idx0), 8'(tbl[i].idx));
      chk("last0",  8'(last0), 8'(tbl[i].last));
      chk("multi0", 8'(multi0), 8'(tbl[i].multi));
      chk("zero0",  8'(zero0), 8'(tbl[i].zero));
      chk("ready0", 8'(rdy0), 8'(tbl[i].rdy));
      chk("valid1", 8'(v1), 8'(tbl[i].v));
      chk("index1", 8'(idx1), 8'(tbl[i].idx_m));
      chk("last1",  8'(last1), 8'(tbl[i].last));
      chk("ready1", 8'(rdy1), 8'(tbl[i].rdy));
    end

    // async reset during the second beat of 0xFF
    row = 1000;
    cycle(1'b1, 8'hFF, 1'b1);
    chk("rst_seq_accept", 8'(rdy0), 8'h1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("rst_seq_beat1_idx0", 8'(idx0), 8'h0);
    chk("rst_seq_beat1_idx1", 8'(idx1), 8'h7);
    cycle(1'b0, 8'h00, 1'b1);
    chk("rst_seq_beat2_valid", 8'(v0), 8'h1);
    chk("rst_seq_beat2_idx0", 8'(idx0), 8'h1);
    chk("rst_seq_beat2_idx1", 8'(idx1), 8'h6);
    #1 rst_n = 1'b0;
    #1;
    chk_both_idle("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    row = 1001;
    cycle(1'b1, 8'h01, 1'b1);
    chk("post_rst_ready0", 8'(rdy0), 8'h1);
    chk("post_rst_valid0", 8'(v0), 8'h0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("post_rst_valid", 8'(v0), 8'h1);
    chk("post_rst_index", 8'(idx0), 8'h0);
    chk("post_rst_last",  8'(last0), 8'h1);
    chk("post_rst_multi", 8'(multi0), 8'h0);
    chk("post_rst_index1", 8'(idx1), 8'h0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("post_rst_done0", 8'(v0), 8'h0);
    chk("post_rst_done1", 8'(v1), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
